// File: rtl/clkdiv_frac_mash_pkg.sv
// Shared mode encodings and correction select for the fractional clock divider.
// Pure definitions; no timing or flow-control behaviour.
package clkdiv_frac_mash_pkg;

    typedef enum logic [1:0] {
        MODE_INT    = 2'd0,
        MODE_DS1    = 2'd1,
        MODE_MASH11 = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    // Reserved encoding falls into the default arm and behaves as integer-only.
    function automatic logic signed [2:0] corr_sel(input logic [1:0] mode,
                                                   input logic c1, input logic c2,
                                                   input logic c2d);
        case (mode)
            MODE_DS1:    corr_sel = $signed({2'b00, c1});
            MODE_MASH11: corr_sel = $signed({2'b00, c1}) + $signed({2'b00, c2})
                                  - $signed({2'b00, c2d});
            default:     corr_sel = 3'sd0;
        endcase
    endfunction

endpackage

// File: rtl/clkdiv_frac_mash_if.sv
// Configuration and divided-clock outputs of the fractional divider.
// Outputs are registered; there is no backpressure on this bundle.
interface clkdiv_frac_mash_if #(
    parameter int W_DIV_INT  = 16,
    parameter int W_DIV_FRAC = 8
);
    logic                  en;
    logic [W_DIV_INT-1:0]  div_int;
    logic [W_DIV_FRAC-1:0] div_frac;
    logic [1:0]            mode;
    logic                  clk_en;
    logic                  clk_out;
    logic [W_DIV_INT:0]    period;

    modport master (output en, div_int, div_frac, mode,
                    input  clk_en, clk_out, period);
    modport slave  (input  en, div_int, div_frac, mode,
                    output clk_en, clk_out, period);
endinterface

// File: rtl/clkdiv_dsm_mash11.sv
// First-order / MASH 1-1 fractional accumulators; corr uses carries from the previous step.
// corr is combinational from registered carries; state advances only on step, no backpressure.
module clkdiv_dsm_mash11
    import clkdiv_frac_mash_pkg::*;
#(
    parameter int W_DIV_FRAC = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  step,
    input  logic [W_DIV_FRAC-1:0] frac,
    input  logic [1:0]            mode,
    output logic signed [2:0]     corr
);
    logic [W_DIV_FRAC-1:0] r_acc1;
    logic [W_DIV_FRAC-1:0] r_acc2;
    logic                  r_c1_q;
    logic                  r_c2_q;
    logic                  r_c2_qq;
    logic [W_DIV_FRAC:0]   w_sum1;
    logic [W_DIV_FRAC:0]   w_sum2;
    logic                  w_mash;

    assign w_sum1 = {1'b0, r_acc1} + {1'b0, frac};
    assign w_sum2 = {1'b0, r_acc2} + {1'b0, w_sum1[W_DIV_FRAC-1:0]};
    assign w_mash = (mode == MODE_MASH11);
    assign corr   = corr_sel(mode, r_c1_q, r_c2_q, r_c2_qq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc1  <= '0;
            r_acc2  <= '0;
            r_c1_q  <= 1'b0;
            r_c2_q  <= 1'b0;
            r_c2_qq <= 1'b0;
        end else if (clr) begin
            r_acc1  <= '0;
            r_acc2  <= '0;
            r_c1_q  <= 1'b0;
            r_c2_q  <= 1'b0;
            r_c2_qq <= 1'b0;
        end else if (step) begin
            r_acc1  <= w_sum1[W_DIV_FRAC-1:0];
            r_acc2  <= w_sum2[W_DIV_FRAC-1:0];
            r_c1_q  <= w_sum1[W_DIV_FRAC];
            // Second-stage carry history only exists in MASH mode.
            r_c2_q  <= w_mash ? w_sum2[W_DIV_FRAC] : 1'b0;
            r_c2_qq <= w_mash ? r_c2_q : 1'b0;
        end
    end
endmodule

// File: rtl/clkdiv_frac_mash.sv
// Fractional-N clock divider producing a clk_en pulse and a square wave at div_int + div_frac/2^F.
// clk_en one cycle after each reload; settings are sampled only at reloads; no backpressure.
module clkdiv_frac_mash
    import clkdiv_frac_mash_pkg::*;
#(
    parameter int W_DIV_INT  = 16,
    parameter int W_DIV_FRAC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    clkdiv_frac_mash_if.slave bus
);
    localparam logic [W_DIV_INT:0]   CTR_ONE = {{W_DIV_INT{1'b0}}, 1'b1};
    localparam logic [W_DIV_INT-1:0] INT_ONE = {{(W_DIV_INT-1){1'b0}}, 1'b1};
    localparam logic signed [W_DIV_INT+1:0] P_MIN = {{(W_DIV_INT+1){1'b0}}, 1'b1};
    localparam logic signed [W_DIV_INT+1:0] P_MAX = {1'b0, {(W_DIV_INT+1){1'b1}}};

    logic [W_DIV_INT:0]    r_ctr;
    logic [W_DIV_INT:0]    r_period;
    logic                  r_clk_en;
    logic                  r_clk_out;
    logic [W_DIV_INT-1:0]  r_sh_int;
    logic [W_DIV_FRAC-1:0] r_sh_frac;
    logic [1:0]            r_sh_mode;

    logic                  w_reload;
    logic                  w_hold;
    logic [W_DIV_INT-1:0]  w_int_sel;
    logic [W_DIV_FRAC-1:0] w_frac_sel;
    logic [1:0]            w_mode_sel;
    logic signed [2:0]     w_corr;
    logic signed [W_DIV_INT+1:0] w_p_raw;
    logic [W_DIV_INT:0]    w_p;
    logic [W_DIV_INT:0]    w_ctr_nxt;
    logic [W_DIV_INT:0]    w_per_nxt;

    // On a reload the live inputs are what gets captured, so the new period uses them directly.
    assign w_reload   = bus.en && (r_ctr == CTR_ONE);
    assign w_int_sel  = w_reload ? bus.div_int  : r_sh_int;
    assign w_frac_sel = w_reload ? bus.div_frac : r_sh_frac;
    assign w_mode_sel = w_reload ? bus.mode     : r_sh_mode;
    assign w_hold     = (w_int_sel <= INT_ONE);

    clkdiv_dsm_mash11 #(.W_DIV_FRAC(W_DIV_FRAC)) u_dsm (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!bus.en || (w_reload && w_hold)),
        .step  (w_reload),
        .frac  (w_frac_sel),
        .mode  (w_mode_sel),
        .corr  (w_corr)
    );

    assign w_p_raw = $signed({2'b00, w_int_sel})
                   + $signed({{(W_DIV_INT-1){w_corr[2]}}, w_corr});

    always_comb begin
        w_p = w_p_raw[W_DIV_INT:0];
        if (w_hold || (w_p_raw < P_MIN)) begin
            w_p = CTR_ONE;
        end else if (w_p_raw > P_MAX) begin
            w_p = P_MAX[W_DIV_INT:0];
        end
    end

    always_comb begin
        w_ctr_nxt = r_ctr - CTR_ONE;
        w_per_nxt = r_period;
        if (w_reload) begin
            w_ctr_nxt = w_p;
            w_per_nxt = w_p;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctr     <= CTR_ONE;
            r_period  <= CTR_ONE;
            r_clk_en  <= 1'b0;
            r_clk_out <= 1'b0;
            r_sh_int  <= '0;
            r_sh_frac <= '0;
            r_sh_mode <= '0;
        end else if (!bus.en) begin
            r_ctr     <= CTR_ONE;
            r_clk_en  <= 1'b0;
            r_clk_out <= 1'b0;
        end else begin
            r_ctr     <= w_ctr_nxt;
            r_period  <= w_per_nxt;
            r_clk_en  <= w_reload;
            // High while the count is in the upper half: ceil(P/2) cycles from the pulse.
            r_clk_out <= (w_ctr_nxt > (w_per_nxt >> 1));
            if (w_reload) begin
                r_sh_int  <= bus.div_int;
                r_sh_frac <= bus.div_frac;
                r_sh_mode <= bus.mode;
            end
        end
    end

    assign bus.clk_en  = r_clk_en;
    assign bus.clk_out = r_clk_out;
    assign bus.period  = r_period;
endmodule

// File: tb/tb_clkdiv_frac_mash.sv
// Directed bench: expected period lengths are queued when a configuration is applied and popped per clk_en pulse.
module tb_clkdiv_frac_mash;
    localparam int WI = 16;
    localparam int WF = 8;

    logic clk;
    logic rst_n;

    clkdiv_frac_mash_if #(.W_DIV_INT(WI), .W_DIV_FRAC(WF)) bus ();

    clkdiv_frac_mash #(.W_DIV_INT(WI), .W_DIV_FRAC(WF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_t = 0;
    int cur_exp = 0;
    bit have_prev = 0;
    bit sb_on = 0;
    int exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One cycle; outputs sampled at the falling edge. Each pulse pops the next expected period.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (sb_on && bus.clk_en === 1'b1) begin
            if (have_prev) check("interval", cyc - last_t, cur_exp);
            last_t = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'(bus.clk_en), 0);
            end else begin
                cur_exp = exp_q.pop_front();
                check("period", 32'(bus.period), cur_exp);
                have_prev = 1;
            end
        end
    endtask

    // Reference: accumulators start cleared, corr uses carries of the previous reload.
    task automatic model_push(input int m, input int di, input int df, input int n);
        int a1, a2, c1q, c2q, c2qq, s1, s2, corr, p, modv;
        modv = 1 << WF;
        a1 = 0; a2 = 0; c1q = 0; c2q = 0; c2qq = 0;
        for (int k = 0; k < n; k++) begin
            if (di <= 1) begin
                p = 1;
            end else begin
                if (m == 1)      corr = c1q;
                else if (m == 2) corr = c1q + c2q - c2qq;
                else             corr = 0;
                p = di + corr;
                if (p < 1) p = 1;
                s1 = a1 + df;
                s2 = a2 + (s1 % modv);
                a1 = s1 % modv;
                a2 = s2 % modv;
                c2qq = (m == 2) ? c2q : 0;
                c2q  = (m == 2) ? int'(s2 >= modv) : 0;
                c1q  = int'(s1 >= modv);
            end
            exp_q.push_back(p);
        end
    endtask

    task automatic arm(input int m, input int di, input int df, input int n, input string tag);
        exp_q.delete();
        have_prev = 0;
        bus.mode     = 2'(m);
        bus.div_int  = WI'(di);
        bus.div_frac = WF'(df);
        model_push(m, di, df, n);
        sb_on  = 1;
        bus.en = 1'b1;
        tick();
        check({tag, "_first_clk_en"}, 32'(bus.clk_en), 1);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 5000) begin
            tick();
            guard++;
        end
        check({tag, "_drain_left"}, exp_q.size(), 0);
    endtask

    // Starting on a pulse cycle, count cycles until n further pulses have been seen.
    task automatic span(input int n, output int cycles, output int pmin, output int pmax);
        int t0, cnt, guard;
        t0 = cyc; cnt = 0; guard = 0; pmin = 1 << 30; pmax = 0;
        while (cnt < n && guard < 20000) begin
            tick();
            guard++;
            if (bus.clk_en === 1'b1) begin
                cnt++;
                if (int'(bus.period) < pmin) pmin = int'(bus.period);
                if (int'(bus.period) > pmax) pmax = int'(bus.period);
            end
        end
        cycles = cyc - t0;
    endtask

    initial begin
        logic [3:0] pat;
        int sp, mn, mx;
        rst_n        = 1'b1;
        bus.en       = 1'b0;
        bus.div_int  = '0;
        bus.div_frac = '0;
        bus.mode     = '0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        check("rst_clk_en", 32'(bus.clk_en), 0);
        check("rst_clk_out", 32'(bus.clk_out), 0);
        check("rst_period", 32'(bus.period), 1);
        rst_n = 1'b1;
        tick();
        check("idle_clk_en", 32'(bus.clk_en), 0);

        // Integer mode ignores the fraction; square wave 1100.
        arm(0, 4, 'h80, 6, "s32");
        drain("s32");
        sb_on = 0;
        pat = 4'b1100;
        for (int i = 0; i < 4; i++) begin
            check("s32_clk_out", 32'(bus.clk_out), 32'(pat[3-i]));
            tick();
        end

        // First order, 4.5: 4,4,5,4,5,... and 1152 cycles per 256 pulses.
        bus.en = 1'b0; tick();
        arm(1, 4, 'h80, 8, "s33");
        drain("s33");
        sb_on = 0;
        span(256, sp, mn, mx);
        check("s33_span", sp, 1152);

        // MASH 1-1, 4.25: periods within 3..6 and 4352 cycles per 1024 pulses.
        bus.en = 1'b0; tick();
        arm(2, 4, 'h40, 16, "s34");
        drain("s34");
        sb_on = 0;
        span(1024, sp, mn, mx);
        check("s34_span", sp, 4352);
        check("s34_range", 32'(mn >= 3 && mx <= 6), 1);

        // div_int change mid-period only takes effect at the next reload.
        bus.en = 1'b0; tick();
        arm(0, 8, 0, 3, "s35");
        drain("s35a");
        tick();
        tick();
        bus.div_int = WI'(3);
        model_push(0, 3, 0, 4);
        drain("s35b");
        sb_on = 0;

        // en low mid-period; restart from cleared accumulators.
        bus.en = 1'b0; tick();
        arm(1, 4, 'h80, 5, "s36a");
        drain("s36a");
        tick();
        tick();
        sb_on = 0;
        bus.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s36_en_low_clk_en", 32'(bus.clk_en), 0);
            check("s36_en_low_clk_out", 32'(bus.clk_out), 0);
        end
        arm(1, 4, 'h80, 6, "s36b");
        drain("s36b");
        sb_on = 0;

        // div_int = 1 holds everything high; a nonzero fraction must not perturb it.
        bus.en = 1'b0; tick();
        arm(2, 1, 'hFF, 8, "s37");
        drain("s37");
        sb_on = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s37_clk_en", 32'(bus.clk_en), 1);
            check("s37_clk_out", 32'(bus.clk_out), 1);
            check("s37_period", 32'(bus.period), 1);
        end

        // Reset mid-period abandons it; release behaves like a first enable.
        bus.en = 1'b0; tick();
        arm(1, 4, 'h80, 3, "s37r");
        drain("s37r");
        tick();
        sb_on = 0;
        #2 rst_n = 1'b0;
        #1;
        check("s37r_async_clk_en", 32'(bus.clk_en), 0);
        check("s37r_async_clk_out", 32'(bus.clk_out), 0);
        check("s37r_async_period", 32'(bus.period), 1);
        tick();
        check("s37r_hold_clk_out", 32'(bus.clk_out), 0);
        exp_q.delete();
        have_prev = 0;
        model_push(1, 4, 'h80, 6);
        sb_on = 1;
        rst_n = 1'b1;
        tick();
        check("s37r_restart_clk_en", 32'(bus.clk_en), 1);
        drain("s37r_after");
        sb_on = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
